gate_truth_sequencer: RTL

Controller that sequences a 2-input combinational gate under test (the OR/AND/XOR family of gates) through all four input vectors, samples its output after a programmable settle time, and compares the results against an expected truth table. It replaces hand-written stimulus sequences with an on-chip start/done checker and sits between a top-level test controller and the gate's `in0`/`in1`/`out` pins.

---
 rtl/gate_seq_pkg.sv | 24 ++
 rtl/gate_seq_timer.sv | 36 +++
 rtl/gate_truth_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// Shared FSM encodings, truth-table constants and a compare helper for the
// gate truth-table sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;

    // One when the observed gate output disagrees with the table entry at idx.
    function automatic logic is_mismatch(input logic [3:0] tt,
                                         input logic [1:0] idx,
                                         input logic       obs);
        is_mismatch = (obs != tt[idx]);
    endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Loadable settle down-counter; expire flags the last enabled cycle of a
// settle window so the caller can reload before the count reaches zero.
module gate_seq_timer
    import gate_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);

    logic [WIDTH-1:0] cnt_r;

    // Settle count register: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == CNT_ONE);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Walks a 2-input gate through 00,01,10,11, samples it after SETTLE_CYCLES and
// scores it against EXPECTED. Define GATE_SEQ_STOP_ON_FAIL_EN to end on first mismatch.
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [3:0]  EXPECTED      = TT_OR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       gate_in0,
    output logic       gate_in1,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] mismatch_count,
    output logic [3:0] result_vec
);

    localparam int unsigned    CW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE_CYCLES);

    state_t     state_r, state_s;
    logic [1:0] idx_r, idx_s;
    logic [1:0] gate_in_r, gate_in_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       pass_r, pass_s;
    logic [2:0] mc_r, mc_s;
    logic [3:0] rv_r, rv_s;
    logic       miss_s;
    logic       stop_s;
    logic       timer_load_s;
    logic       timer_en_s;
    logic       expire_s;

    assign timer_en_s = (state_r == RUN);

    gate_seq_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .en       (timer_en_s),
        .load_val (SETTLE_LD),
        .expire   (expire_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        gate_in_s    = gate_in_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        pass_s       = pass_r;
        mc_s         = mc_r;
        rv_s         = rv_r;
        timer_load_s = 1'b0;
        miss_s       = is_mismatch(EXPECTED, idx_r, gate_out);
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        stop_s       = (idx_r == 2'd3) || miss_s;
`else
        stop_s       = (idx_r == 2'd3);
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    idx_s        = 2'd0;
                    rv_s         = 4'd0;
                    mc_s         = 3'd0;
                    pass_s       = 1'b0;
                    gate_in_s    = 2'b00;
                    busy_s       = 1'b1;
                    timer_load_s = 1'b1;
                    state_s      = RUN;
                end else begin
                    state_s      = IDLE;
                end
            end
            RUN: begin
                if (expire_s) begin
                    rv_s[idx_r] = gate_out;
                    mc_s        = mc_r + {2'b00, miss_s};
                    if (stop_s) begin
                        state_s   = DONE;
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                        pass_s    = (mc_s == 3'd0);
                        gate_in_s = 2'b00;
                    end else begin
                        idx_s        = idx_r + 2'd1;
                        gate_in_s    = idx_r + 2'd1;
                        timer_load_s = 1'b1;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s   = IDLE;
                busy_s    = 1'b0;
                gate_in_s = 2'b00;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= 2'd0;
            gate_in_r <= 2'b00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            mc_r      <= 3'd0;
            rv_r      <= 4'd0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            gate_in_r <= gate_in_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            pass_r    <= pass_s;
            mc_r      <= mc_s;
            rv_r      <= rv_s;
        end
    end

    assign gate_in0       = gate_in_r[0];
    assign gate_in1       = gate_in_r[1];
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign mismatch_count = mc_r;
    assign result_vec     = rv_r;

endmodule
